ip_apb_slave: RTL and testbench



---
 rtl/ip_apb_slave_pkg.sv | 19 +
 rtl/ip_apb_slave_if.sv | 32 +++
 rtl/ip_addr_decoder.sv | 30 +++
 rtl/ip_apb_slave.sv | 133 +++++++++++++
 tb/tb_ip_apb_slave.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/ip_apb_slave_pkg.sv
// Shared definitions for the timer IP APB front end: register map,
// one-hot register select codes and the slave FSM state encoding.
package ip_apb_slave_pkg;

    localparam logic [7:0] TDR_ADDR_DEF = 8'h00;
    localparam logic [7:0] TCR_ADDR_DEF = 8'h01;
    localparam logic [7:0] TSR_ADDR_DEF = 8'h02;

    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_TDR  = 4'b0001;
    localparam logic [3:0] SEL_TCR  = 4'b0010;
    localparam logic [3:0] SEL_TSR  = 4'b0100;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/ip_apb_slave_if.sv
// APB bus bundle between a master and the timer slave front end.
interface ip_apb_slave_if;

    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic       pready;
    logic       pslverr;

    modport master (
        output psel,
        output penable,
        output pwrite,
        output paddr,
        output pwdata,
        input  pready,
        input  pslverr
    );

    modport slave (
        input  psel,
        input  penable,
        input  pwrite,
        input  paddr,
        input  pwdata,
        output pready,
        output pslverr
    );

endinterface

// File: rtl/ip_addr_decoder.sv
// Combinational paddr decode into the one-hot timer register select.
// Any address outside the map yields SEL_NONE with the error flag set.
module ip_addr_decoder
    import ip_apb_slave_pkg::*;
#(
    parameter logic [7:0] TDR_ADDR = TDR_ADDR_DEF,
    parameter logic [7:0] TCR_ADDR = TCR_ADDR_DEF,
    parameter logic [7:0] TSR_ADDR = TSR_ADDR_DEF
) (
    input  logic [7:0] paddr_i,
    output logic [3:0] select_o,
    output logic       err_o
);

    // Address map lookup.
    always_comb begin
        select_o = SEL_NONE;
        err_o    = 1'b0;
        case (paddr_i)
            TDR_ADDR: select_o = SEL_TDR;
            TCR_ADDR: select_o = SEL_TCR;
            TSR_ADDR: select_o = SEL_TSR;
            default: begin
                select_o = SEL_NONE;
                err_o    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ip_apb_slave.sv
// APB slave front end of the 16-bit timer: decodes the register select,
// inserts WAIT_CYCLES wait states and issues the register write strobe.
module ip_apb_slave
    import ip_apb_slave_pkg::*;
#(
    parameter int         WAIT_CYCLES = 0,
    parameter logic [7:0] TDR_ADDR    = TDR_ADDR_DEF,
    parameter logic [7:0] TCR_ADDR    = TCR_ADDR_DEF,
    parameter logic [7:0] TSR_ADDR    = TSR_ADDR_DEF
) (
    input  logic                pclk,
    input  logic                preset,
    ip_apb_slave_if.slave       apb,
    output logic [3:0]          select_reg,
    output logic                wr_en,
    output logic [7:0]          wdata
);

    generate
        if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 7)) begin : g_bad_wait_cycles
            $error("ip_apb_slave: WAIT_CYCLES must be within 0..7");
        end
    endgenerate

    localparam logic [2:0] CNT_INIT = 3'(WAIT_CYCLES);
    localparam logic       RDY_INIT = (WAIT_CYCLES == 0) ? 1'b1 : 1'b0;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       pready_q, pready_d;
    logic [3:0] select_q, select_d;
    logic       err_q, err_d;
    logic       pwrite_q, pwrite_d;
    logic [7:0] wdata_q, wdata_d;

    logic [3:0] dec_select_s;
    logic       dec_err_s;
    logic       setup_s;

    ip_addr_decoder #(
        .TDR_ADDR (TDR_ADDR),
        .TCR_ADDR (TCR_ADDR),
        .TSR_ADDR (TSR_ADDR)
    ) u_addr_decoder (
        .paddr_i  (apb.paddr),
        .select_o (dec_select_s),
        .err_o    (dec_err_s)
    );

    assign setup_s = apb.psel & ~apb.penable;

    // State and output registers with synchronous reset.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            pready_q <= 1'b0;
            select_q <= SEL_NONE;
            err_q    <= 1'b0;
            pwrite_q <= 1'b0;
            wdata_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pready_q <= pready_d;
            select_q <= select_d;
            err_q    <= err_d;
            pwrite_q <= pwrite_d;
            wdata_q  <= wdata_d;
        end
    end

    // Next-state logic; a SETUP seen in ACCESS restarts the transfer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pready_d = pready_q;
        select_d = select_q;
        err_d    = err_q;
        pwrite_d = pwrite_q;
        wdata_d  = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (setup_s) begin
                    state_d  = ST_ACCESS;
                    cnt_d    = CNT_INIT;
                    pready_d = RDY_INIT;
                    select_d = dec_select_s;
                    err_d    = dec_err_s;
                    pwrite_d = apb.pwrite;
                    wdata_d  = apb.pwdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!apb.psel) begin
                    state_d  = ST_IDLE;
                    pready_d = 1'b0;
                    select_d = SEL_NONE;
                end else if (!apb.penable) begin
                    state_d  = ST_ACCESS;
                    cnt_d    = CNT_INIT;
                    pready_d = RDY_INIT;
                    select_d = dec_select_s;
                    err_d    = dec_err_s;
                    pwrite_d = apb.pwrite;
                    wdata_d  = apb.pwdata;
                end else if (pready_q) begin
                    state_d  = ST_IDLE;
                    pready_d = 1'b0;
                    select_d = SEL_NONE;
                end else begin
                    cnt_d    = cnt_q - 3'd1;
                    pready_d = (cnt_q == 3'd1) ? 1'b1 : 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                pready_d = 1'b0;
                select_d = SEL_NONE;
            end
        endcase
    end

    assign apb.pready  = pready_q;
    assign apb.pslverr = pready_q & err_q;
    assign select_reg  = select_q;
    assign wdata       = wdata_q;
    // Live psel/penable gate the strobe so an abort can never write.
    assign wr_en       = pready_q & apb.psel & apb.penable & pwrite_q & ~err_q;

endmodule

// File: tb/tb_ip_apb_slave.sv
// Directed bench for ip_apb_slave: three instances (0, 2, 3 wait states)
// share one stimulus bus; each step checks the instance of interest.
module tb_ip_apb_slave;

    logic       pclk;
    logic       preset;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;

    int checks = 0;
    int errors = 0;

    ip_apb_slave_if if0 ();
    ip_apb_slave_if if2 ();
    ip_apb_slave_if if3 ();

    assign if0.psel = psel;   assign if0.penable = penable; assign if0.pwrite = pwrite;
    assign if0.paddr = paddr; assign if0.pwdata = pwdata;
    assign if2.psel = psel;   assign if2.penable = penable; assign if2.pwrite = pwrite;
    assign if2.paddr = paddr; assign if2.pwdata = pwdata;
    assign if3.psel = psel;   assign if3.penable = penable; assign if3.pwrite = pwrite;
    assign if3.paddr = paddr; assign if3.pwdata = pwdata;

    logic [3:0] sel0, sel2, sel3;
    logic       wr0, wr2, wr3;
    logic [7:0] wd0, wd2, wd3;

    ip_apb_slave #(.WAIT_CYCLES(0)) dut0 (
        .pclk(pclk), .preset(preset), .apb(if0), .select_reg(sel0), .wr_en(wr0), .wdata(wd0));
    ip_apb_slave #(.WAIT_CYCLES(2)) dut2 (
        .pclk(pclk), .preset(preset), .apb(if2), .select_reg(sel2), .wr_en(wr2), .wdata(wd2));
    ip_apb_slave #(.WAIT_CYCLES(3)) dut3 (
        .pclk(pclk), .preset(preset), .apb(if3), .select_reg(sel3), .wr_en(wr3), .wdata(wd3));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Back-to-back monitor for dut0: completion cycles and write pulses.
    int   cyc = 0;
    logic mon_en = 1'b0;
    int   mon_wr = 0;
    int   mon_rdy_cyc[$];
    always @(posedge pclk) cyc <= cyc + 1;
    always @(negedge pclk) begin
        if (mon_en) begin
            if (wr0) mon_wr = mon_wr + 1;
            if (if0.pready) mon_rdy_cyc.push_back(cyc);
        end
    end

    function automatic logic [14:0] E(input logic r, input logic e, input logic [3:0] s,
                                      input logic w, input logic [7:0] d);
        return {r, e, s, w, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic [14:0] exp);
        chk(tag, {17'd0, if0.pready, if0.pslverr, sel0, wr0, wd0}, {17'd0, exp});
    endtask
    task automatic chk2(input string tag, input logic [14:0] exp);
        chk(tag, {17'd0, if2.pready, if2.pslverr, sel2, wr2, wd2}, {17'd0, exp});
    endtask
    task automatic chk3(input string tag, input logic [14:0] exp);
        chk(tag, {17'd0, if3.pready, if3.pslverr, sel3, wr3, wd3}, {17'd0, exp});
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask
    task automatic setup(input logic w, input logic [7:0] a, input logic [7:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        #1;
    endtask
    task automatic access();
        penable = 1'b1;
        #1;
    endtask
    task automatic idle();
        psel = 1'b0; penable = 1'b0;
        #1;
    endtask

    initial begin : watchdog
        #50000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 8'h00;
        tick(); tick();
        preset = 1'b0;
        #1;
        chk0("reset_w0", E(1'b0, 1'b0, 4'b0000, 1'b0, 8'h00));
        chk2("reset_w2", E(1'b0, 1'b0, 4'b0000, 1'b0, 8'h00));
        chk3("reset_w3", E(1'b0, 1'b0, 4'b0000, 1'b0, 8'h00));

        // Write TCR with no wait states; address/data change during ACCESS.
        tick(); setup(1'b1, 8'h01, 8'hA5);
        chk0("w0_setup", E(1'b0, 1'b0, 4'b0000, 1'b0, 8'h00));
        tick(); paddr = 8'h07; pwdata = 8'hFF; access();
        chk0("w0_complete", E(1'b1, 1'b0, 4'b0010, 1'b1, 8'hA5));
        tick(); idle();
        chk0("w0_after", E(1'b0, 1'b0, 4'b0000, 1'b0, 8'hA5));

        // Read TSR with two wait states.
        tick(); setup(1'b0, 8'h02, 8'h5A);
        tick(); access();
        chk2("rd_acc1", E(1'b0, 1'b0, 4'b0100, 1'b0, 8'h5A));
        tick();
        chk2("rd_acc2", E(1'b0, 1'b0, 4'b0100, 1'b0, 8'h5A));
        tick();
        chk2("rd_acc3", E(1'b1, 1'b0, 4'b0100, 1'b0, 8'h5A));
        tick(); idle();
        chk2("rd_after", E(1'b0, 1'b0, 4'b0000, 1'b0, 8'h5A));

        // Write to an unmapped address.
        tick(); setup(1'b1, 8'h07, 8'hC3);
        tick(); access();
        chk0("err_complete", E(1'b1, 1'b1, 4'b0000, 1'b0, 8'hC3));
        tick(); idle();
        chk0("err_after", E(1'b0, 1'b0, 4'b0000, 1'b0, 8'hC3));

        // Abort in the second ACCESS cycle with three wait states.
        tick(); setup(1'b1, 8'h00, 8'h77);
        tick(); access();
        chk3("abort_acc1", E(1'b0, 1'b0, 4'b0001, 1'b0, 8'h77));
        tick(); idle();
        chk3("abort_acc2", E(1'b0, 1'b0, 4'b0001, 1'b0, 8'h77));
        tick();
        chk3("abort_idle1", E(1'b0, 1'b0, 4'b0000, 1'b0, 8'h77));
        tick(); tick();
        chk3("abort_idle3", E(1'b0, 1'b0, 4'b0000, 1'b0, 8'h77));

        // Reset mid-transfer, then a clean write to TDR.
        tick(); setup(1'b1, 8'h01, 8'h99);
        tick(); access();
        chk2("rst_acc1", E(1'b0, 1'b0, 4'b0010, 1'b0, 8'h99));
        preset = 1'b1;
        tick(); preset = 1'b0; idle();
        chk2("rst_cleared", E(1'b0, 1'b0, 4'b0000, 1'b0, 8'h00));
        tick(); setup(1'b1, 8'h00, 8'h3C);
        tick(); access();
        chk2("post_rst_acc1", E(1'b0, 1'b0, 4'b0001, 1'b0, 8'h3C));
        tick();
        chk2("post_rst_acc2", E(1'b0, 1'b0, 4'b0001, 1'b0, 8'h3C));
        tick();
        chk2("post_rst_done", E(1'b1, 1'b0, 4'b0001, 1'b1, 8'h3C));
        tick(); idle();
        chk2("post_rst_after", E(1'b0, 1'b0, 4'b0000, 1'b0, 8'h3C));

        // penable drops in ACCESS: treated as a fresh SETUP.
        tick(); setup(1'b1, 8'h00, 8'hAA);
        tick(); access();
        tick(); setup(1'b0, 8'h02, 8'hBB);
        chk2("resetup_old", E(1'b0, 1'b0, 4'b0001, 1'b0, 8'hAA));
        tick(); access();
        chk2("resetup_new", E(1'b0, 1'b0, 4'b0100, 1'b0, 8'hBB));
        tick(); idle();

        // Back-to-back write then read, no wait states.
        tick(); mon_en = 1'b1; setup(1'b1, 8'h00, 8'h11);
        tick(); access();
        chk0("b2b_wr_done", E(1'b1, 1'b0, 4'b0001, 1'b1, 8'h11));
        tick(); setup(1'b0, 8'h01, 8'h11);
        chk0("b2b_rd_setup", E(1'b0, 1'b0, 4'b0000, 1'b0, 8'h11));
        tick(); access();
        chk0("b2b_rd_done", E(1'b1, 1'b0, 4'b0010, 1'b0, 8'h11));
        tick(); idle();
        tick(); mon_en = 1'b0;
        chk("b2b_wr_pulses", mon_wr, 1);
        chk("b2b_completions", mon_rdy_cyc.size(), 2);
        if (mon_rdy_cyc.size() == 2)
            chk("b2b_spacing", mon_rdy_cyc[1] - mon_rdy_cyc[0], 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
